// File: rtl/mux_scan_controller.sv
// Scan sequencer for a 4:1 mux: steps the select lines over enabled channels,
// samples the mux output after each dwell and publishes a 4-bit frame.
module mux_scan_controller #(
  parameter int unsigned DWELL = 2,
  parameter int unsigned CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [3:0] mask_i,
  input  logic       y_i,
  output logic       s0_o,
  output logic       s1_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] frame_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         work_q, work_d;
  logic [3:0]         mask_q, mask_d;
  logic [3:0]         frame_q, frame_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [2:0]         first_ch;
  logic [2:0]         next_ch;
  logic [3:0]         work_merged;

  // Lowest enabled channel in m; when first=0 only channels above cur qualify.
  // Result is {found, index}.
  function automatic logic [2:0] pick_ch(input logic [3:0] m, input logic [1:0] cur,
                                         input logic first);
    logic [2:0] res;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      if (m[k] && (first || (3'(k) > {1'b0, cur}))) begin
        res = {1'b1, 2'(k)};
      end
    end
    return res;
  endfunction

  assign first_ch = pick_ch(mask_i, 2'b00, 1'b1);
  assign next_ch  = pick_ch(mask_q, sel_q, 1'b0);

  always_comb begin
    work_merged        = work_q;
    work_merged[sel_q] = y_i;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    mask_d  = mask_q;
    frame_d = frame_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        sel_d  = 2'b00;
        busy_d = 1'b0;
        if (start_i) begin
          if (mask_i != 4'b0000) begin
            mask_d  = mask_i;
            work_d  = 4'b0000;
            sel_d   = first_ch[1:0];
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = ST_SCAN;
          end else begin
            mask_d  = 4'b0000;
            frame_d = 4'b0000;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_SCAN: begin
        if (cnt_q != CNT_W'(DWELL - 1)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          // End of dwell: capture y for the current channel, then advance or finish.
          work_d = work_merged;
          cnt_d  = '0;
          if (next_ch[2]) begin
            sel_d = next_ch[1:0];
          end else begin
            frame_d = work_merged;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            sel_d   = 2'b00;
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        sel_d   = 2'b00;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'b00;
      cnt_q   <= '0;
      work_q  <= 4'b0000;
      mask_q  <= 4'b0000;
      frame_q <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      mask_q  <= mask_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign s0_o    = sel_q[0];
  assign s1_o    = sel_q[1];
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign frame_o = frame_q;

endmodule

// File: doc/mux_scan_controller.md
Name: mux_scan_controller

Overview:
Sequencer that sits directly upstream of the 4:1 dataflow mux: it drives the mux select lines s0/s1 and reads back the mux output y.
On a start request it walks the enabled channels in ascending index order and holds each selection for DWELL clock cycles.
It samples y at the end of each dwell and assembles the samples into a 4-bit frame, one bit per channel.
It then signals completion with a one-cycle done pulse, turning the combinational mux into a scanned input port.

Parameters:
DWELL, 2, clock cycles each selection is held before y is sampled; legal range 1..15.
CNT_W, 4, width of the dwell counter; must satisfy 2^CNT_W > DWELL.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  scan request; sampled only in IDLE.
mask  input  4  channel enable, bit k enables channel k; latched on an accepted start.
y  input  1  mux output, fed back from the mux.
s0  output  1  mux select LSB; channel index = {s1,s0}.
s1  output  1  mux select MSB.
busy  output  1  high while a scan is in progress (SCAN state).
done  output  1  one-cycle pulse when frame is updated.
frame  output  4  last completed scan result; bit k = sampled y for channel k, 0 for masked channels.

Behaviour:
- Reset (rst=1 at an edge, in any state, including mid-scan): state=IDLE, s0=s1=0, busy=0, done=0, frame=4'b0000, dwell counter=0, working frame=0, latched mask=0. The partial scan is discarded and no done is produced.
- All outputs are registered; no combinational path exists from y, start or mask to any output.
- States: IDLE, SCAN, DONE.
- IDLE, start=1 and mask!=0:
  - latch mask, clear working frame, select the lowest enabled channel, clear the dwell counter.
  - go to SCAN; busy=1 from the next cycle.
- IDLE, start=1 and mask==0: go to DONE directly; frame<=0; done=1 in the next cycle; s0/s1 stay 0.
- IDLE, start=0: hold; s0=s1=0.
- SCAN, each cycle:
  - when counter < DWELL-1: increment the counter.
  - when counter == DWELL-1: working bit [ch] <= y, counter <= 0.
    - if a higher enabled channel exists in the latched mask, {s1,s0} <= the next higher enabled channel (skip masked channels, no wrap).
    - otherwise go to DONE: frame <= working frame with this final bit merged, done<=1, busy<=0, s0=s1=0.
- DONE: lasts exactly one cycle with done=1, then IDLE unconditionally. start asserted in DONE is ignored.
- start and mask changes during SCAN or DONE are ignored; the latched mask governs the whole scan.
- frame holds its value between scans and changes only on the transition into DONE.
- Timing, start accepted at edge E0 with n enabled channels:
  - busy=1 and the first select is valid in the cycle after E0.
  - done=1 during the cycle following edge E0 + n*DWELL.
  - e.g. mask=4'hF, DWELL=2: done appears 9 cycles after the start edge.
- y for channel k is sampled at the rising edge that ends the last dwell cycle of k. This gives the mux DWELL cycles of settling after the select changes.
- A new scan can be accepted the cycle after DONE (back-to-back scans have one idle cycle between them).

Test Plan:
- Reset then idle: rst=1 for 2 cycles, start=0 -> s0=s1=0, busy=0, done=0, frame=0000 throughout.
- Full scan against a mux model with i0=1, i1=0, i2=1, i3=0; mask=1111, DWELL=2, one-cycle start pulse:
  - {s1,s0} steps 0,0,1,1,2,2,3,3 over 8 cycles; busy=1 for those 8 cycles.
  - done pulses once, 9 cycles after start; frame=0101.
- Sparse mask=1010, same mux inputs -> only selects 1 and 3 are driven (2 cycles each); frame=0000. With i1=1, i3=1 -> frame=1010.
- mask=0000 with start -> done pulses in the next cycle; busy never rises; frame=0000.
- Mid-scan disturbances:
  - start pulses and mask changes during SCAN -> no effect on the sequence or the result.
  - rst=1 after the second channel -> all outputs return to reset values at the next edge; no done; the previous frame is cleared to 0.
- DWELL=1 build, mask=1111, y tied to s0 -> a new select every cycle; frame=1010; done 5 cycles after start.
